mfu_batch_sched: RTL and testbench



---
 rtl/mfu_batch_sched.sv | 188 ++++++++++++++++++
 tb/tb_mfu_batch_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mfu_batch_sched.sv
// MFU scheduler: expands queued macro instructions into size*batch micro instructions.
// Latency: a write at t reaches the first uop at t+2. Holds uops under backpressure and deasserts write-ready when the queue is full.
module mfu_batch_sched #(
  parameter int VRFAW  = 9,
  parameter int NSIZEW = 9,
  parameter int NTAGW  = 5,
  parameter int OPW    = 6,
  parameter int NBATCH = 4,
  parameter int BW     = $clog2(NBATCH) + 1,
  parameter int QDEPTH = 32,
  parameter int MIW    = OPW + 1 + NTAGW + NSIZEW + BW + 2*NBATCH*VRFAW,
  parameter int UIW    = 1 + 2*VRFAW + NTAGW + OPW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_minst_wr_en,
  output logic            o_minst_wr_rdy,
  input  logic [MIW-1:0]  i_minst_wr_din,
  output logic            o_uinst_valid,
  input  logic            i_uinst_ready,
  output logic [UIW-1:0]  o_uinst_dout,
  output logic            o_idle,
  output logic [15:0]     o_discard_cnt
);

  localparam int QAW       = $clog2(QDEPTH);
  localparam int OFF_TAG   = OPW + 1;
  localparam int OFF_SIZE  = OFF_TAG + NTAGW;
  localparam int OFF_BATCH = OFF_SIZE + NSIZEW;
  localparam int OFF_V1    = OFF_BATCH + BW;
  localparam int OFF_V0    = OFF_V1 + NBATCH*VRFAW;
  localparam logic [BW-1:0] NB_L = BW'(NBATCH);

  typedef enum logic {IDLE, ISSUE} state_t;

  // ---------------- input queue (first-word fall-through) ----------------
  logic [MIW-1:0] q_mem [QDEPTH];
  logic [QAW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic           q_empty, q_full, q_push, q_pop;
  logic [MIW-1:0] q_head;

  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[QAW] != rd_ptr_q[QAW]) &&
                   (wr_ptr_q[QAW-1:0] == rd_ptr_q[QAW-1:0]);
  // Ready reflects the registered fill level, so a pop never frees room for a same-cycle write.
  assign q_push  = i_minst_wr_en && !q_full;
  assign q_head  = q_mem[rd_ptr_q[QAW-1:0]];
  assign wr_ptr_d = q_push ? wr_ptr_q + (QAW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = q_pop  ? rd_ptr_q + (QAW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (q_push) q_mem[wr_ptr_q[QAW-1:0]] <= i_minst_wr_din;
  end

  // ---------------- head decode ----------------
  logic [OPW-1:0]                 head_op;
  logic                           head_func;
  logic [NTAGW-1:0]               head_tag;
  logic [NSIZEW-1:0]              head_size;
  logic [BW-1:0]                  head_batch, head_batch_clamp;
  logic [NBATCH-1:0][VRFAW-1:0]   head_v0, head_v1;
  logic                           head_discard;

  assign head_op    = q_head[OPW-1:0];
  assign head_func  = q_head[OPW];
  assign head_tag   = q_head[OFF_TAG +: NTAGW];
  assign head_size  = q_head[OFF_SIZE +: NSIZEW];
  assign head_batch = q_head[OFF_BATCH +: BW];
  assign head_v1    = q_head[OFF_V1 +: NBATCH*VRFAW];
  assign head_v0    = q_head[OFF_V0 +: NBATCH*VRFAW];
  assign head_batch_clamp = (head_batch > NB_L) ? NB_L : head_batch;
  assign head_discard = (&q_head) || !head_func ||
                        (head_size == '0) || (head_batch == '0);

  // ---------------- scheduler state ----------------
  state_t                       state_q, state_d;
  logic [NSIZEW-1:0]            c_q, c_d;
  logic [BW-1:0]                b_q, b_d;
  logic [15:0]                  disc_cnt_q, disc_cnt_d;
  logic [OPW-1:0]               op_q;
  logic [NTAGW-1:0]             tag_q;
  logic [NSIZEW-1:0]            size_q;
  logic [BW-1:0]                batch_q;
  logic [NBATCH-1:0][VRFAW-1:0] base0_q, base1_q;
  logic                         load, discard, last;
  logic [VRFAW-1:0]             vrf0_addr, vrf1_addr;

  assign last = (c_q == size_q - NSIZEW'(1)) && (b_q == batch_q - BW'(1));

  always_comb begin
    vrf0_addr = '0;
    vrf1_addr = '0;
    for (int i = 0; i < NBATCH; i++) begin
      if (b_q == BW'(i)) begin
        vrf0_addr = base0_q[i] + VRFAW'(c_q);
        vrf1_addr = base1_q[i] + VRFAW'(c_q);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    b_d     = b_q;
    q_pop   = 1'b0;
    load    = 1'b0;
    discard = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!q_empty) begin
          q_pop = 1'b1;
          if (head_discard) begin
            discard = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (i_uinst_ready) begin
          if (last) begin
            // Chain straight into the next queued instruction to avoid a bubble.
            if (q_empty) begin
              state_d = IDLE;
            end else begin
              q_pop = 1'b1;
              if (head_discard) begin
                discard = 1'b1;
                state_d = IDLE;
              end else begin
                load = 1'b1;
              end
            end
          end else if (b_q == batch_q - BW'(1)) begin
            b_d = '0;
            c_d = c_q + NSIZEW'(1);
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      c_d = '0;
      b_d = '0;
    end
    disc_cnt_d = disc_cnt_q;
    if (discard && disc_cnt_q != 16'hFFFF) disc_cnt_d = disc_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      c_q        <= '0;
      b_q        <= '0;
      disc_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      b_q        <= b_d;
      disc_cnt_q <= disc_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      op_q    <= head_op;
      tag_q   <= head_tag;
      size_q  <= head_size;
      batch_q <= head_batch_clamp;
      base0_q <= head_v0;
      base1_q <= head_v1;
    end
  end

  assign o_minst_wr_rdy = !q_full;
  assign o_uinst_valid  = (state_q == ISSUE);
  assign o_uinst_dout   = {last, vrf0_addr, vrf1_addr, tag_q, op_q};
  assign o_idle         = (state_q == IDLE) && q_empty;
  assign o_discard_cnt  = disc_cnt_q;

endmodule

// File: tb/tb_mfu_batch_sched.sv
// Directed bench for mfu_batch_sched; inputs driven and outputs sampled on the falling edge.
module tb_mfu_batch_sched;
  localparam int MIW = 96;
  localparam int UIW = 30;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic           wr_rdy;
  logic [MIW-1:0] wr_din = '0;
  logic           u_valid;
  logic           u_ready = 1'b0;
  logic [UIW-1:0] u_dout;
  logic           idle;
  logic [15:0]    disc_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mfu_batch_sched dut (
    .clk            (clk),
    .rst            (rst),
    .i_minst_wr_en  (wr_en),
    .o_minst_wr_rdy (wr_rdy),
    .i_minst_wr_din (wr_din),
    .o_uinst_valid  (u_valid),
    .i_uinst_ready  (u_ready),
    .o_uinst_dout   (u_dout),
    .o_idle         (idle),
    .o_discard_cnt  (disc_cnt)
  );

  function automatic logic [MIW-1:0] mk(input logic [5:0] op, input logic func,
      input logic [4:0] tag, input logic [8:0] size, input logic [2:0] batch,
      input logic [3:0][8:0] v0, input logic [3:0][8:0] v1);
    mk = {v0, v1, batch, size, tag, func, op};
  endfunction

  function automatic logic [UIW-1:0] ue(input logic last, input logic [8:0] v0,
      input logic [8:0] v1, input logic [4:0] tag, input logic [5:0] op);
    ue = {last, v0, v1, tag, op};
  endfunction

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; u_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (u_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", u_valid); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_cmp++; if (disc_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", disc_cnt); end
    n_cmp++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", wr_rdy); end
  endtask

  task automatic test_basic();
    int e0[6] = '{10, 20, 30, 11, 21, 31};
    int e1[6] = '{100, 200, 300, 101, 201, 301};
    do_reset();
    u_ready = 1'b1;
    wr_en = 1'b1;
    wr_din = mk(6'd5, 1'b1, 5'd3, 9'd2, 3'd3, {9'd0, 9'd30, 9'd20, 9'd10}, {9'd0, 9'd300, 9'd200, 9'd100});
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++; if (u_valid !== 1'b0) begin n_fail++; $display("FAIL basic_t1_valid: got %b want 0", u_valid); end
    @(negedge clk);
    n_cmp++; if (u_valid !== 1'b1) begin n_fail++; $display("FAIL basic_t2_valid: got %b want 1", u_valid); end
    for (int k = 0; k < 6; k++) begin
      logic [UIW-1:0] exp_u;
      exp_u = ue(k == 5, 9'(e0[k]), 9'(e1[k]), 5'd3, 6'd5);
      n_cmp++;
      if (u_valid !== 1'b1 || u_dout !== exp_u) begin
        n_fail++; $display("FAIL basic_uop%0d: got v=%b %h want v=1 %h", k, u_valid, u_dout, exp_u);
      end
      @(negedge clk);
    end
    n_cmp++; if (u_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL basic_end: got v=%b idle=%b want v=0 idle=1", u_valid, idle); end
  endtask

  task automatic test_discards();
    logic seen = 1'b0;
    logic [MIW-1:0] w[4];
    w[0] = '1;
    w[1] = mk(6'd5, 1'b0, 5'd3, 9'd2, 3'd3, {4{9'd1}}, {4{9'd2}});
    w[2] = mk(6'd5, 1'b1, 5'd3, 9'd0, 3'd3, {4{9'd1}}, {4{9'd2}});
    w[3] = mk(6'd5, 1'b1, 5'd3, 9'd2, 3'd0, {4{9'd1}}, {4{9'd2}});
    do_reset();
    u_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (u_valid) seen = 1'b1;
      if (i < 4) begin wr_en = 1'b1; wr_din = w[i]; end
      else wr_en = 1'b0;
      @(negedge clk);
    end
    if (u_valid) seen = 1'b1;
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL disc_no_uop: got %b want 0", seen); end
    n_cmp++; if (disc_cnt !== 16'd4) begin n_fail++; $display("FAIL disc_cnt: got %0d want 4", disc_cnt); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL disc_idle: got %b want 1", idle); end
  endtask

  task automatic test_back_to_back();
    logic [UIW-1:0] exp_u[5];
    exp_u[0] = ue(1'b1, 9'd50, 9'd60, 5'd1, 6'd1);
    exp_u[1] = ue(1'b0, 9'd10, 9'd20, 5'd2, 6'd2);
    exp_u[2] = ue(1'b0, 9'd11, 9'd21, 5'd2, 6'd2);
    exp_u[3] = ue(1'b0, 9'd12, 9'd22, 5'd2, 6'd2);
    exp_u[4] = ue(1'b1, 9'd13, 9'd23, 5'd2, 6'd2);
    do_reset();
    u_ready = 1'b1;
    wr_en = 1'b1;
    wr_din = mk(6'd1, 1'b1, 5'd1, 9'd1, 3'd1, {9'd0, 9'd0, 9'd0, 9'd50}, {9'd0, 9'd0, 9'd0, 9'd60});
    @(negedge clk);
    wr_din = mk(6'd2, 1'b1, 5'd2, 9'd1, 3'd7, {9'd13, 9'd12, 9'd11, 9'd10}, {9'd23, 9'd22, 9'd21, 9'd20});
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (u_valid !== 1'b1 || u_dout !== exp_u[k]) begin
        n_fail++; $display("FAIL chain_uop%0d: got v=%b %h want v=1 %h", k, u_valid, u_dout, exp_u[k]);
      end
      @(negedge clk);
    end
    n_cmp++; if (u_valid !== 1'b0) begin n_fail++; $display("FAIL chain_end: got %b want 0", u_valid); end
  endtask

  task automatic test_backpressure();
    logic [UIW-1:0] exp_u[3];
    int budget = 0;
    exp_u[0] = ue(1'b0, 9'd511, 9'd7, 5'd4, 6'd7);
    exp_u[1] = ue(1'b0, 9'd0,   9'd8, 5'd4, 6'd7);
    exp_u[2] = ue(1'b1, 9'd1,   9'd9, 5'd4, 6'd7);
    do_reset();
    wr_en = 1'b1;
    wr_din = mk(6'd7, 1'b1, 5'd4, 9'd3, 3'd1, {9'd0, 9'd0, 9'd0, 9'd511}, {9'd0, 9'd0, 9'd0, 9'd7});
    @(negedge clk);
    wr_en = 1'b0;
    while (!u_valid && budget < 5) begin @(negedge clk); budget++; end
    n_cmp++; if (u_valid !== 1'b1) begin n_fail++; $display("FAIL bp_start: got %b want 1", u_valid); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (u_valid !== 1'b1 || u_dout !== exp_u[k]) begin
        n_fail++; $display("FAIL bp_uop%0d: got v=%b %h want v=1 %h", k, u_valid, u_dout, exp_u[k]);
      end
      u_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (u_valid !== 1'b1 || u_dout !== exp_u[k]) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b %h want v=1 %h", k, u_valid, u_dout, exp_u[k]);
      end
      u_ready = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (u_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL bp_end: got v=%b idle=%b want v=0 idle=1", u_valid, idle); end
  endtask

  task automatic test_full_queue();
    do_reset();
    for (int i = 0; i < 34; i++) begin
      n_cmp++;
      if (wr_rdy !== (i <= 32)) begin
        n_fail++; $display("FAIL full_rdy%0d: got %b want %b", i, wr_rdy, (i <= 32));
      end
      wr_en = 1'b1;
      wr_din = mk(6'(i), 1'b1, 5'(i), 9'd1, 3'd1, {9'd0, 9'd0, 9'd0, 9'(i)}, {9'd0, 9'd0, 9'd0, 9'(i + 100)});
      @(negedge clk);
    end
    wr_en = 1'b0;
    u_ready = 1'b1;
    for (int k = 0; k < 33; k++) begin
      logic [UIW-1:0] exp_u;
      exp_u = ue(1'b1, 9'(k), 9'(k + 100), 5'(k), 6'(k));
      n_cmp++;
      if (u_valid !== 1'b1 || u_dout !== exp_u) begin
        n_fail++; $display("FAIL full_uop%0d: got v=%b %h want v=1 %h", k, u_valid, u_dout, exp_u);
      end
      @(negedge clk);
    end
    n_cmp++; if (u_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL full_end: got v=%b idle=%b want v=0 idle=1", u_valid, idle); end
  endtask

  task automatic test_reset_mid_issue();
    int n = 0;
    int budget = 0;
    logic seen = 1'b0;
    do_reset();
    u_ready = 1'b1;
    wr_en = 1'b1;
    wr_din = '1;
    @(negedge clk);
    wr_din = mk(6'd9, 1'b1, 5'd6, 9'd4, 3'd1, {9'd0, 9'd0, 9'd0, 9'd40}, {9'd0, 9'd0, 9'd0, 9'd80});
    @(negedge clk);
    wr_en = 1'b0;
    while (n < 3 && budget < 10) begin
      if (u_valid) n++;
      if (n < 3) begin @(negedge clk); budget++; end
    end
    n_cmp++;
    if (n !== 3 || u_dout !== ue(1'b0, 9'd42, 9'd82, 5'd6, 6'd9)) begin
      n_fail++; $display("FAIL rmid_3rd: got n=%0d %h want n=3 %h", n, u_dout, ue(1'b0, 9'd42, 9'd82, 5'd6, 6'd9));
    end
    n_cmp++; if (disc_cnt !== 16'd1) begin n_fail++; $display("FAIL rmid_cnt_pre: got %0d want 1", disc_cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (u_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", u_valid); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rmid_idle: got %b want 1", idle); end
    n_cmp++; if (disc_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 0", disc_cnt); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (u_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_no_uop: got %b want 0", seen); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_discards();
    test_back_to_back();
    test_backpressure();
    test_full_queue();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
